// File: rtl/instr_mem_loader_if.sv
// Byte-stream source and instruction-memory write port for the loader.
// The master side is the loader; the slave side is the host/memory.
interface instr_mem_loader_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;

    modport master (
        input  s_valid, s_data,
        output s_ready, mem_addr, mem_data, mem_wren
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a little-endian byte stream into instruction memory word by word,
// holding the CPU in reset and accumulating a mod-2^32 checksum.
module instr_mem_loader (
    input  logic                      MAX10_CLK1_50,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                load_len,
    instr_mem_loader_if.master        bus,
    output logic                      cpu_hold,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               checksum
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_len;
    logic [7:0]  r_idx;
    logic [1:0]  r_bcnt;
    logic [31:0] r_word;
    logic [31:0] r_sum;
    logic        w_take;
    logic        w_last;

    assign w_take   = bus.s_valid & bus.s_ready;
    assign w_last   = (r_idx == r_len);
    assign busy     = cpu_hold;
    assign checksum = r_sum;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        bus.s_ready  = 1'b0;
        bus.mem_wren = 1'b0;
        bus.mem_addr = 8'h00;
        bus.mem_data = 32'h0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                cpu_hold = 1'b0;
                if (start) begin
                    w_next = RECV;
                end
            end
            RECV: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid && (r_bcnt == 2'd3)) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                bus.mem_wren = 1'b1;
                bus.mem_addr = r_idx;
                bus.mem_data = r_word;
                w_next       = w_last ? DONE : RECV;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
        endcase
    end

    // Word index stops at the latched length, so 255 never wraps to 0.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            r_len  <= 8'h00;
            r_idx  <= 8'h00;
            r_bcnt <= 2'd0;
            r_word <= 32'h0;
            r_sum  <= 32'h0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_len  <= load_len;
                r_idx  <= 8'h00;
                r_bcnt <= 2'd0;
                r_sum  <= 32'h0;
            end
            if (w_take) begin
                r_word[{r_bcnt, 3'b000} +: 8] <= bus.s_data;
                r_bcnt                        <= r_bcnt + 2'd1;
            end
            if (r_state == WRITE) begin
                r_sum <= r_sum + r_word;
                if (!w_last) begin
                    r_idx <= r_idx + 8'd1;
                end
            end
        end
    end

endmodule
